// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the reduced RV32I datapath.
// Build option MC_CTRL_ILLEGAL_TRAP_EN: unsupported encodings trap into HALT instead of retiring as NOPs.
module mc_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ALUctrl_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DATA_WIDTH-1:0]    instr,
    input  logic                     Zero,
    output logic                     IRen,
    output logic                     PCen,
    output logic                     PCsrc,
    output logic                     JALRctrl,
    output logic                     RegWrite,
    output logic                     MemWrite,
    output logic                     ALUsrc,
    output logic [ALUctrl_WIDTH-1:0] ALUctrl,
    output logic [1:0]               ResultSrc,
    output logic [2:0]               ImmSrc,
    output logic                     retire,
    output logic                     illegal
);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_PASSB = 3'b110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    typedef enum logic [2:0] {C_NOP, C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP} cls_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic                  illegal_q, illegal_d;
    logic                  pcen_q, pcen_d;
    logic                  regwrite_q, regwrite_d;
    logic                  memwrite_q, memwrite_d;
    logic                  jump_q, jump_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_ir;

    cls_t       cls;
    logic       alu_src;
    logic       jalr_ctrl;
    logic [2:0] alu_op;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic [2:0] f3_alu;
    logic       f3_ok;
    logic       taken;

    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign funct7    = ir_q[31:25];
    assign unused_ir = ^{ir_q[24:15], ir_q[11:7]};

    // funct3 map shared by the register and immediate ALU forms
    always_comb begin
        f3_ok  = 1'b1;
        f3_alu = ALU_ADD;
        case (funct3)
            3'b000:  f3_alu = ALU_ADD;
            3'b111:  f3_alu = ALU_AND;
            3'b110:  f3_alu = ALU_OR;
            3'b010:  f3_alu = ALU_SLT;
            default: f3_ok  = 1'b0;
        endcase
    end

    // Decoded fields come straight from IR, so they stay put from DECODE until the next fetch
    always_comb begin
        cls        = C_NOP;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        imm_src    = IMM_I;
        result_src = 2'b00;
        jalr_ctrl  = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    cls    = C_ALU;
                    alu_op = ALU_SUB;
                end else if (funct7 == 7'b0000000 && f3_ok) begin
                    cls    = C_ALU;
                    alu_op = f3_alu;
                end
            end
            OP_I: begin
                if (f3_ok) begin
                    cls     = C_ALU;
                    alu_src = 1'b1;
                    alu_op  = f3_alu;
                end
            end
            OP_LW: begin
                if (funct3 == 3'b010) begin
                    cls        = C_LOAD;
                    alu_src    = 1'b1;
                    result_src = 2'b01;
                end
            end
            OP_SW: begin
                if (funct3 == 3'b010) begin
                    cls     = C_STORE;
                    alu_src = 1'b1;
                    imm_src = IMM_S;
                end
            end
            OP_BR: begin
                if (funct3[2:1] == 2'b00) begin
                    cls     = C_BRANCH;
                    alu_op  = ALU_SUB;
                    imm_src = IMM_B;
                end
            end
            OP_JAL: begin
                cls        = C_JUMP;
                imm_src    = IMM_J;
                result_src = 2'b10;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    cls        = C_JUMP;
                    alu_src    = 1'b1;
                    jalr_ctrl  = 1'b1;
                    result_src = 2'b10;
                end
            end
            OP_LUI: begin
                cls     = C_ALU;
                alu_src = 1'b1;
                alu_op  = ALU_PASSB;
                imm_src = IMM_U;
            end
            default: ;
        endcase
    end

    // Strobes are computed for the state being entered, so they appear registered in that state
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        illegal_d  = illegal_q;
        pcen_d     = 1'b0;
        regwrite_d = 1'b0;
        memwrite_d = 1'b0;
        jump_d     = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (en) begin
                    ir_d    = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (TRAP_EN && cls == C_NOP) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    state_d = S_EXEC;
                    pcen_d  = (cls == C_BRANCH) || (cls == C_NOP);
                end
            end
            S_EXEC: begin
                case (cls)
                    C_LOAD:  state_d = S_MEM;
                    C_STORE: begin
                        state_d    = S_MEM;
                        memwrite_d = 1'b1;
                        pcen_d     = 1'b1;
                    end
                    C_ALU, C_JUMP: begin
                        state_d    = S_WB;
                        regwrite_d = 1'b1;
                        pcen_d     = 1'b1;
                        jump_d     = (cls == C_JUMP);
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (cls == C_LOAD) begin
                    state_d    = S_WB;
                    regwrite_d = 1'b1;
                    pcen_d     = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            ir_q       <= '0;
            illegal_q  <= 1'b0;
            pcen_q     <= 1'b0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            jump_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            illegal_q  <= illegal_d;
            pcen_q     <= pcen_d;
            regwrite_q <= regwrite_d;
            memwrite_q <= memwrite_d;
            jump_q     <= jump_d;
        end
    end

    // Zero arrives combinationally during EXEC; gating by rst keeps an aborted instruction silent
    assign taken     = funct3[0] ? ~Zero : Zero;
    assign IRen      = ~rst & en & (state_q == S_FETCH);
    assign PCen      = ~rst & pcen_q;
    assign retire    = ~rst & pcen_q;
    assign RegWrite  = ~rst & regwrite_q;
    assign MemWrite  = ~rst & memwrite_q;
    assign PCsrc     = ~rst & (jump_q | ((state_q == S_EXEC) && (cls == C_BRANCH) && taken));
    assign JALRctrl  = jalr_ctrl;
    assign ALUsrc    = alu_src;
    assign ALUctrl   = ALUctrl_WIDTH'(alu_op);
    assign ResultSrc = result_src;
    assign ImmSrc    = imm_src;
    assign illegal   = ~rst & illegal_q;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the reduced RV32I datapath. Latches each fetched instruction into an internal instruction register, then steps it through FETCH/DECODE/EXEC/MEM/WB. Drives the datapath's control inputs (RegWrite, MemWrite, ALUsrc, ALUctrl, ResultSrc, JALRctrl) and the PC update. Sits between instruction memory/PC register and the register-file/ALU/data-memory datapath, replacing the single-cycle decoder.

## Interface
- DATA_WIDTH, 32, instruction width
- ALUctrl_WIDTH, 3, ALU control width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable; sampled only in FETCH
- instr  in  DATA_WIDTH  instruction-memory read data at current PC
- Zero  in  1  ALU zero flag, same-cycle combinational from datapath
- IRen  out  1  instruction-register load strobe
- PCen  out  1  PC register update strobe
- PCsrc  out  1  0: PC<=PC+4, 1: PC<=PCTarget
- JALRctrl  out  1  PCTarget taken from ALUout
- RegWrite  out  1  register-file write strobe
- MemWrite  out  1  data-memory write strobe
- ALUsrc  out  1  0: rs2 operand, 1: immediate
- ALUctrl  out  ALUctrl_WIDTH  000 add, 001 sub, 010 and, 011 or, 101 slt, 110 pass-B
- ResultSrc  out  2  00 ALUout, 01 read data, 1x PCPlus4
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- retire  out  1  one-cycle pulse in the last state of each instruction
- illegal  out  1  sticky illegal-instruction flag

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT; reset state FETCH.
- FETCH: if en=1, IRen=1, IR<=instr, go DECODE; if en=0, stay, all strobes 0.
- DECODE: classify IR opcode; no strobes; go EXEC (or HALT if illegal, see Configuration).
- ALUsrc/ALUctrl/ImmSrc/ResultSrc/JALRctrl decoded from IR, held stable DECODE..last state.
- R-type 0110011: funct3/funct7 000/0 add, 000/0100000 sub, 111 and, 110 or, 010 slt; EXEC->WB; WB: RegWrite, ResultSrc=00.
- I-ALU 0010011: addi/andi/ori/slti, ALUsrc=1; EXEC->WB as R-type.
- lw 0000011 funct3 010: add, ALUsrc=1; EXEC->MEM->WB; WB: RegWrite, ResultSrc=01.
- sw 0100011 funct3 010: add, ALUsrc=1, ImmSrc=S; EXEC->MEM; MEM: MemWrite, last state.
- beq/bne 1100011 funct3 000/001: sub, ALUsrc=0, ImmSrc=B; EXEC last state; taken = Zero (beq) / !Zero (bne), PCsrc=taken.
- jal 1101111: EXEC->WB; WB: RegWrite, ResultSrc=10, PCsrc=1.
- jalr 1100111 funct3 000: add, ALUsrc=1, JALRctrl=1; EXEC->WB as jal.
- lui 0110111: ALUctrl=110, ALUsrc=1, ImmSrc=U; EXEC->WB as R-type.
- Last state of every instruction: PCen=1, retire=1, next state FETCH.
- Exactly one PCen, at most one RegWrite, at most one MemWrite per instruction.
- Writes to rd=x0 still assert RegWrite; register file discards.

## Timing
- While rst=1 and the cycle after release: state FETCH, IR=0, illegal=0, all strobes 0 (IRen follows en after release).
- rst mid-instruction: abort at next edge, no further strobes; partial instruction never retires.
- Cycles per instruction (en=1): branch 3; R/I-ALU, lui, sw, jal, jalr 4; lw 5.
- Zero consumed combinationally in EXEC only; datapath must hold operands stable there.
- en deasserted mid-instruction: instruction completes; controller then parks in FETCH.
- Back-to-back: FETCH of next instruction immediately follows last state.

## Configuration
- MC_CTRL_ILLEGAL_TRAP_EN defined: unsupported opcode/funct in DECODE sets illegal=1, goes HALT; HALT emits no strobes, PC not advanced, exits only on rst.
- Undefined: unsupported encodings execute as NOP: DECODE->EXEC, EXEC is last state (PCen, PCsrc=0, retire), no RegWrite/MemWrite; illegal tied 0.

## Test plan
- addi x1,x0,5 (0x00500093), en=1 -> IRen c0, RegWrite+PCen+retire c3 only, ALUsrc=1, ALUctrl=000, PCsrc=0.
- lw x2,0(x1) then sw x2,4(x1) -> lw RegWrite c4 ResultSrc=01; sw MemWrite c3 of its sequence, no RegWrite; 9 cycles total.
- beq x1,x1,+8 with Zero=1 -> EXEC c2 PCen=1, PCsrc=1, ALUctrl=001; repeat bne with Zero=1 -> PCsrc=0.
- jalr x1,0(x5) -> WB: RegWrite, ResultSrc=10, PCsrc=1, JALRctrl=1, PCen=1.
- instr=0xFFFFFFFF: with macro -> illegal=1, HALT, no PCen for 20 cycles until rst; without -> retire at c2, PCsrc=0, no writes.
- rst asserted in lw MEM state -> next cycle FETCH, no RegWrite/PCen; en=0 after release -> no IRen for 10 cycles.
